// File: rtl/cache_pkg.sv
// cache_pkg
// Shared definitions for the data cache and its line-transfer controller:
// word/line geometry, the line-base helper and the controller state type.
package cache_pkg;

  localparam int ADDR_W   = 32;
  localparam int WORD_W   = 32;
  localparam int WORDS    = 16;
  localparam int LINE_W   = WORDS * WORD_W;
  localparam int OFFSET_W = 4;

  typedef enum logic [2:0] {
    IDLE,
    WB,
    RD_ISSUE,
    RD_WAIT,
    DONE
  } line_state_t;

  // Clear the word-offset bits so any word address maps to its line base.
  function automatic logic [ADDR_W-1:0] line_base(input logic [ADDR_W-1:0] addr);
    return addr & {{(ADDR_W-OFFSET_W){1'b1}}, {OFFSET_W{1'b0}}};
  endfunction

endpackage

// File: rtl/dirty_pick.sv
// dirty_pick
// Combinational lowest-set-bit encoder over a per-word dirty mask. Used by
// the line controller to serialise write-backs, and usable for a flush walk.
//   mask     in   WORDS     dirty-word mask
//   idx      out  OFFSET_W  index of the lowest set bit (0 when mask is empty)
//   any_set  out  1         mask has at least one bit set
module dirty_pick
  import cache_pkg::*;
(
  input  logic [WORDS-1:0]    mask,
  output logic [OFFSET_W-1:0] idx,
  output logic                any_set
);

  // Scanning from the top down lets the lowest set bit overwrite last.
  always_comb begin
    idx     = '0;
    any_set = |mask;
    for (int i = WORDS - 1; i >= 0; i--) begin
      if (mask[i]) idx = OFFSET_W'(i);
    end
  end

endmodule

// File: rtl/mem_line_ctrl.sv
// mem_line_ctrl
// Miss-service engine between the direct-mapped data cache and main memory.
// Each accepted request runs an optional victim write-back (dirty words only,
// lowest index first) followed by an optional 16-word refill, serialised over
// a single-outstanding 32-bit word port. The refilled line is returned whole.
//   clk, rst_n          clock, asynchronous active-low reset
//   req_*               cache request (accepted on req_valid & req_ready)
//   resp_valid/data     completion pulse and last refilled line
//   mem_*               word port to memory (mem_rvalid returns read data)
//   fill_cnt, wb_cnt    saturating counts of refills and written-back words
module mem_line_ctrl
  import cache_pkg::*;
(
  input  logic              clk,
  input  logic              rst_n,
  input  logic              req_valid,
  output logic              req_ready,
  input  logic              req_fill,
  input  logic [ADDR_W-1:0] req_fill_addr,
  input  logic [WORDS-1:0]  req_wb_mask,
  input  logic [ADDR_W-1:0] req_wb_addr,
  input  logic [LINE_W-1:0] req_wb_data,
  output logic              resp_valid,
  output logic [LINE_W-1:0] resp_data,
  output logic              mem_req,
  output logic              mem_we,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [WORD_W-1:0] mem_wdata,
  input  logic              mem_ready,
  input  logic              mem_rvalid,
  input  logic [WORD_W-1:0] mem_rdata,
  output logic [31:0]       fill_cnt,
  output logic [31:0]       wb_cnt
);

  localparam logic [31:0]         CNT_MAX  = 32'hFFFF_FFFF;
  localparam logic [OFFSET_W-1:0] LAST_IDX = OFFSET_W'(WORDS - 1);

  line_state_t         state, next_state;
  logic                fill_q;
  logic [ADDR_W-1:0]   wb_base, fill_base;
  logic [WORDS-1:0]    mask_q, mask_clr;
  logic [LINE_W-1:0]   wb_data_q;
  logic [LINE_W-1:0]   line_buf;
  logic [OFFSET_W-1:0] word_idx;
  logic [OFFSET_W-1:0] wb_idx;
  logic                wb_any;

  dirty_pick u_pick (
    .mask    (mask_q),
    .idx     (wb_idx),
    .any_set (wb_any)
  );

  // Mask as it will look once the word currently on the port is accepted;
  // an empty result means this is the last write-back beat.
  assign mask_clr = mask_q & ~(WORDS'(1) << wb_idx);

  // Next state and port decode. The port payload depends only on registered
  // state, so it holds steady for as long as memory stalls.
  always_comb begin
    next_state = state;
    req_ready  = 1'b0;
    resp_valid = 1'b0;
    mem_req    = 1'b0;
    mem_we     = 1'b0;
    mem_addr   = '0;
    mem_wdata  = '0;
    case (state)
      IDLE: begin
        req_ready = 1'b1;
        if (req_valid) begin
          if (|req_wb_mask)  next_state = WB;
          else if (req_fill) next_state = RD_ISSUE;
          else               next_state = DONE;
        end
      end
      WB: begin
        mem_req   = wb_any;
        mem_we    = 1'b1;
        mem_addr  = wb_base | ADDR_W'(wb_idx);
        mem_wdata = wb_data_q[wb_idx*WORD_W +: WORD_W];
        if (!wb_any || (mem_ready && mask_clr == '0))
          next_state = fill_q ? RD_ISSUE : DONE;
      end
      RD_ISSUE: begin
        mem_req  = 1'b1;
        mem_addr = fill_base | ADDR_W'(word_idx);
        if (mem_ready) next_state = RD_WAIT;
      end
      RD_WAIT: begin
        mem_addr = fill_base | ADDR_W'(word_idx);
        if (mem_rvalid) next_state = (word_idx == LAST_IDX) ? DONE : RD_ISSUE;
      end
      DONE: begin
        resp_valid = 1'b1;
        next_state = IDLE;
      end
      default: next_state = IDLE;
    endcase
  end

  // State register plus request capture, write-back bookkeeping and line
  // assembly. The line is built in line_buf and copied to resp_data only on
  // the final word, so a refill in progress never disturbs the last response
  // and an aborted one leaves nothing behind.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= IDLE;
      fill_q    <= 1'b0;
      wb_base   <= '0;
      fill_base <= '0;
      mask_q    <= '0;
      wb_data_q <= '0;
      line_buf  <= '0;
      word_idx  <= '0;
      resp_data <= '0;
      fill_cnt  <= '0;
      wb_cnt    <= '0;
    end else begin
      state <= next_state;
      case (state)
        IDLE: begin
          if (req_valid) begin
            fill_q    <= req_fill;
            wb_base   <= line_base(req_wb_addr);
            fill_base <= line_base(req_fill_addr);
            mask_q    <= req_wb_mask;
            wb_data_q <= req_wb_data;
            word_idx  <= '0;
          end
        end
        WB: begin
          if (wb_any && mem_ready) begin
            mask_q <= mask_clr;
            if (wb_cnt != CNT_MAX) wb_cnt <= wb_cnt + 32'd1;
          end
        end
        RD_WAIT: begin
          if (mem_rvalid) begin
            line_buf[word_idx*WORD_W +: WORD_W] <= mem_rdata;
            if (word_idx == LAST_IDX) begin
              resp_data <= {mem_rdata, line_buf[LINE_W-WORD_W-1:0]};
              word_idx  <= '0;
              if (fill_cnt != CNT_MAX) fill_cnt <= fill_cnt + 32'd1;
            end else begin
              word_idx <= word_idx + 1'b1;
            end
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: doc/mem_line_ctrl.md
# mem_line_ctrl

Line-transfer controller between the direct-mapped data cache and main memory. Accepts one miss-service request per transaction: an optional victim write-back (dirty words only) followed by an optional 16-word line refill. Serialises both over a 32-bit single-outstanding word port to memory. Returns the assembled 512-bit line to the cache.

## Interface

- ADDR_W, 32, word-granular address width (memory is addressed in 32-bit words)
- WORD_W, 32, memory word width
- WORDS, 16, words per line; LINE_W = WORDS*WORD_W = 512

- clk  in  1  clock, all logic on rising edge
- rst_n  in  1  reset, asynchronous, active-low
- req_valid  in  1  cache presents a request
- req_ready  out  1  high only in IDLE; request accepted on req_valid & req_ready
- req_fill  in  1  1 = refill line at req_fill_addr
- req_fill_addr  in  ADDR_W  any word address in target line; low 4 bits ignored
- req_wb_mask  in  WORDS  dirty-word mask of victim; all-zero = no write-back
- req_wb_addr  in  ADDR_W  victim line address; low 4 bits ignored
- req_wb_data  in  LINE_W  victim line, word k at bits [32k+31:32k]
- resp_valid  out  1  one-cycle pulse: transaction complete
- resp_data  out  LINE_W  refilled line; stable from resp_valid until next refill completes
- mem_req  out  1  memory access request
- mem_we  out  1  1 = write, 0 = read
- mem_addr  out  ADDR_W  word address
- mem_wdata  out  WORD_W  write data
- mem_ready  in  1  memory accepts access on mem_req & mem_ready
- mem_rvalid  in  1  read data valid, at least one cycle after read acceptance
- mem_rdata  in  WORD_W  read data
- fill_cnt  out  32  completed refills, saturating
- wb_cnt  out  32  words written back, saturating

## Operation

- States: IDLE, WB, RD_ISSUE, RD_WAIT, DONE.
- Acceptance registers fill flag, both line bases ({addr[31:4],4'h0}), mask, victim data.
- IDLE -> WB if mask != 0; else RD_ISSUE if req_fill; else DONE.
- WB: drive lowest set mask bit k: mem_we=1, mem_addr=wb_base+k, mem_wdata=word k. On mem_ready: clear bit k, wb_cnt+1. Clean words cost no cycles. Mask empty -> RD_ISSUE if fill, else DONE.
- Write-back always completes before any refill read; refill of the same line address therefore returns the just-written data.
- RD_ISSUE: mem_we=0, mem_addr=fill_base+k, k=0..15 ascending. On mem_ready -> RD_WAIT.
- RD_WAIT: mem_req=0. On mem_rvalid: store mem_rdata at word k. k<15 -> k+1, RD_ISSUE; k=15 -> fill_cnt+1, DONE.
- DONE: resp_valid=1 for one cycle, -> IDLE.
- mem_rvalid outside RD_WAIT is ignored.
- mem_addr wraps modulo 2^ADDR_W. No carry out of the line base, since the offset occupies the low 4 bits only.
- Counters saturate at 32'hFFFF_FFFF.

## Timing

- Reset values: state IDLE, req_ready=1, resp_valid=0, resp_data=0, mem_req=0, mem_we=0, mem_addr=0, mem_wdata=0, fill_cnt=0, wb_cnt=0, word index 0.
- mem_* outputs are registered-state decodes. Payload holds stable while mem_req=1 && !mem_ready.
- Best case (mem_ready=1, rvalid one cycle after accept):
  - n dirty words: n cycles in WB.
  - Refill: 32 cycles (issue + wait per word).
  - DONE: 1 cycle.
  - Full dirty victim + refill: accept at cycle 0, resp_valid at cycle 49.
- Empty request (fill=0, mask=0): resp_valid in cycle after acceptance.
- req_ready=0 from the cycle after acceptance until the cycle after resp_valid. Back-to-back requests: one idle cycle between transactions.
- rst_n assertion mid-transaction aborts immediately. Outputs take reset values. Partially assembled line is discarded. A late mem_rvalid after release is ignored.

## Structure

- Shared package cache_pkg: WORD_W, WORDS, LINE_W, OFFSET_W=4, line-base function, state enum type.
- Sub-module dirty_pick: combinational lowest-set-bit encoder (16-bit mask -> 4-bit index + any flag). Reusable by the cache for flush.

## Test plan

- Refill only:
  - Stimulus: fill_addr=0x0000_0123, memory word a holds a; mem_ready=1.
  - Response: reads at 0x120..0x12F in order; resp_data word k = 0x120+k; resp_valid at cycle 33; fill_cnt=1.
- Sparse write-back + refill:
  - Stimulus: mask=16'h8001, wb_addr=0x40, fill_addr=0x80.
  - Response: writes only to 0x40 and 0x4F, both before the first read at 0x80; wb_cnt=2.
- Same-line write-back then refill:
  - Stimulus: mask=16'hFFFF, wb_addr=fill_addr=0x200, wb word k=0xA000_0000+k.
  - Response: resp_data equals wb data; resp_valid at cycle 49.
- Backpressure:
  - Stimulus: mem_ready low 3 cycles per access, rvalid delay 4.
  - Response: mem_addr/mem_wdata stable while stalled; correct line returned; req_ready low throughout.
- Reset mid-refill:
  - Stimulus: rst_n low after word 7 captured; stray mem_rvalid after release.
  - Response: all outputs at reset values; state IDLE; no resp_valid; counters 0.
- Empty request and saturation:
  - Stimulus: fill=0, mask=0; separately, wb_cnt forced to 32'hFFFF_FFFF then one write-back.
  - Response: resp_valid one cycle after acceptance, no mem_req; wb_cnt stays 32'hFFFF_FFFF.
